// File: rtl/ht_cmd_queue.sv
// Command FIFO in front of hash_table_top. It has a registered first-word-fall-through head,
// a registered in_ready and saturating per-opcode accept counters.
module ht_cmd_queue #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 16,
    parameter int DEPTH_LOG2  = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [KEY_WIDTH-1:0]   in_key_i,
    input  logic [VALUE_WIDTH-1:0] in_value_i,
    input  logic [1:0]             in_opcode_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [KEY_WIDTH-1:0]   out_key_o,
    output logic [VALUE_WIDTH-1:0] out_value_o,
    output logic [1:0]             out_opcode_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DEPTH_LOG2:0]    used_o,
    output logic [CNT_WIDTH-1:0]   cnt_search_o,
    output logic [CNT_WIDTH-1:0]   cnt_insert_o,
    output logic [CNT_WIDTH-1:0]   cnt_delete_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int EW    = KEY_WIDTH + VALUE_WIDTH + 2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [1:0] OP_SEARCH = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;

    logic [EW-1:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     used_q, used_d, remain;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [EW-1:0]           head_q, head_d, in_entry;
    logic [CNT_WIDTH-1:0]    cnt_search_q, cnt_search_d;
    logic [CNT_WIDTH-1:0]    cnt_insert_q, cnt_insert_d;
    logic [CNT_WIDTH-1:0]    cnt_delete_q, cnt_delete_d;
    logic                    push, pop;

    assign in_entry = {in_key_i, in_value_i, in_opcode_i};
    assign push     = in_valid_i & in_ready_q & ~flush_i;
    assign pop      = out_valid_q & out_ready_i;
    // Entries left in storage once this cycle's pop is taken, before the push lands.
    assign remain   = used_q - (DEPTH_LOG2 + 1)'(pop);

    always_comb begin
        wr_ptr_d     = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d     = rd_ptr_q + DEPTH_LOG2'(pop);
        used_d       = remain + (DEPTH_LOG2 + 1)'(push);
        cnt_search_d = cnt_search_q;
        cnt_insert_d = cnt_insert_q;
        cnt_delete_d = cnt_delete_q;
        head_d       = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
        end
        if (push) begin
            if (in_opcode_i == OP_SEARCH && !(&cnt_search_q)) cnt_search_d = cnt_search_q + 1'b1;
            if (in_opcode_i == OP_INSERT && !(&cnt_insert_q)) cnt_insert_d = cnt_insert_q + 1'b1;
            if (in_opcode_i == OP_DELETE && !(&cnt_delete_q)) cnt_delete_d = cnt_delete_q + 1'b1;
        end
        // The new head is the incoming entry only when nothing older survives the pop.
        if (used_d != '0) begin
            if (remain == '0) head_d = in_entry;
            else              head_d = mem_q[rd_ptr_d];
        end
        out_valid_d = (used_d != '0);
        in_ready_d  = (used_d != FULL_LVL);
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            used_q       <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            head_q       <= '0;
            cnt_search_q <= '0;
            cnt_insert_q <= '0;
            cnt_delete_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            used_q       <= used_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            head_q       <= head_d;
            cnt_search_q <= cnt_search_d;
            cnt_insert_q <= cnt_insert_d;
            cnt_delete_q <= cnt_delete_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign used_o       = used_q;
    assign out_key_o    = head_q[EW-1 -: KEY_WIDTH];
    assign out_value_o  = head_q[VALUE_WIDTH+1 -: VALUE_WIDTH];
    assign out_opcode_o = head_q[1:0];
    assign cnt_search_o = cnt_search_q;
    assign cnt_insert_o = cnt_insert_q;
    assign cnt_delete_o = cnt_delete_q;
endmodule

// File: tb/tb_ht_cmd_queue.sv
// Scoreboard bench for ht_cmd_queue: accepted commands are queued by the monitor
// and compared against the head whenever the model says the queue is non-empty.
module tb_ht_cmd_queue;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] in_key_i = '0;
    logic [15:0] in_value_i = '0;
    logic [1:0]  in_opcode_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] out_key_o;
    logic [15:0] out_value_o;
    logic [1:0]  out_opcode_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [3:0]  used_o;
    logic [15:0] cnt_search_o, cnt_insert_o, cnt_delete_o;

    ht_cmd_queue dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_key_i(in_key_i), .in_value_i(in_value_i), .in_opcode_i(in_opcode_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_key_o(out_key_o), .out_value_o(out_value_o), .out_opcode_o(out_opcode_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .used_o(used_o),
        .cnt_search_o(cnt_search_o), .cnt_insert_o(cnt_insert_o), .cnt_delete_o(cnt_delete_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, advanced on the falling edge ahead of the rising edge it predicts.
    logic [49:0] sb[$];
    int m_used = 0;
    bit m_rdy  = 0;
    int m_srch = 0, m_ins = 0, m_del = 0;

    always @(negedge clk_i) begin
        bit m_push, m_pop;
        if (!rst_i) begin
            sb.delete();
            m_used = 0; m_rdy = 0; m_srch = 0; m_ins = 0; m_del = 0;
        end else begin
            chk("used", 64'(used_o), 64'(m_used));
            chk("out_valid", 64'(out_valid_o), 64'(m_used != 0));
            chk("in_ready", 64'(in_ready_o), 64'(m_rdy));
            chk("used_bound", 64'(used_o <= 4'd8), 64'd1);
            chk("cnt_search", 64'(cnt_search_o), 64'(m_srch));
            chk("cnt_insert", 64'(cnt_insert_o), 64'(m_ins));
            chk("cnt_delete", 64'(cnt_delete_o), 64'(m_del));
            if (m_used != 0 && sb.size() > 0)
                chk("head", 64'({out_key_o, out_value_o, out_opcode_o}), 64'(sb[0]));
            m_push = in_valid_i && m_rdy && !flush_i;
            m_pop  = (m_used != 0) && out_ready_i;
            if (m_pop && sb.size() > 0) void'(sb.pop_front());
            if (flush_i) begin
                sb.delete();
                m_used = 0;
            end else begin
                if (m_push) begin
                    sb.push_back({in_key_i, in_value_i, in_opcode_i});
                    if (in_opcode_i == 2'd0) m_srch++;
                    if (in_opcode_i == 2'd1) m_ins++;
                    if (in_opcode_i == 2'd2) m_del++;
                end
                m_used = m_used + int'(m_push) - int'(m_pop);
            end
            m_rdy = (m_used != 8);
        end
    end

    task automatic push_cmd(input logic [31:0] k, input logic [15:0] v, input logic [1:0] op);
        logic acc;
        int n;
        n = 0;
        in_key_i = k; in_value_i = v; in_opcode_i = op; in_valid_i = 1'b1;
        do begin
            @(negedge clk_i); acc = in_ready_o;
            @(posedge clk_i); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready_i = 1'b1;
        while (m_used != 0 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (m_used != 0) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    bit p_done;
    bit tog_run;
    int b_s, b_i, b_d;

    initial begin
        #2;
        chk("rst_used", 64'(used_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_fields", 64'({out_key_o, out_value_o, out_opcode_o}), 64'd0);
        chk("rst_cnt", 64'({cnt_search_o, cnt_insert_o, cnt_delete_o}), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("ready_after_release", 64'(in_ready_o), 64'd1);

        // single insert, latency 1
        out_ready_i = 1'b1;
        push_cmd(32'h0100_0000, 16'h1234, 2'd1);
        chk("t1_valid", 64'(out_valid_o), 64'd1);
        chk("t1_fields", 64'({out_key_o, out_value_o, out_opcode_o}), 64'({32'h0100_0000, 16'h1234, 2'd1}));
        chk("t1_cnt_insert", 64'(cnt_insert_o), 64'd1);
        @(posedge clk_i); #1;
        chk("t1_used", 64'(used_o), 64'd0);
        chk("t1_valid_low", 64'(out_valid_o), 64'd0);

        // fill to full with a stalled consumer, ninth held
        out_ready_i = 1'b0;
        p_done = 0;
        fork
            begin
                for (int i = 0; i < 9; i++) push_cmd(32'hA000_0000 + i, 16'(i * 3), 2'(i % 3));
                p_done = 1;
            end
        join_none
        repeat (11) @(posedge clk_i);
        #1;
        chk("t2_used_full", 64'(used_o), 64'd8);
        chk("t2_not_ready", 64'(in_ready_o), 64'd0);
        chk("t2_ninth_held", 64'(in_valid_i), 64'd1);
        out_ready_i = 1'b1;
        for (int n = 0; n < 50 && !p_done; n++) begin
            @(posedge clk_i); #1;
        end
        chk("t2_ninth_accepted", 64'(p_done), 64'd1);
        drain();

        // wrap with the consumer toggling every cycle
        tog_run = 1;
        fork
            begin
                for (int n = 0; n < 200 && tog_run; n++) begin
                    @(posedge clk_i); #1;
                    out_ready_i = ~out_ready_i;
                end
            end
        join_none
        for (int i = 0; i < 20; i++) push_cmd(32'h5000_0000 ^ (i * 32'h0101), 16'($urandom), 2'($urandom_range(0, 3)));
        tog_run = 0;
        @(posedge clk_i); #1;
        drain();

        // opcode mix, opcode 3 queued but uncounted
        b_s = m_srch; b_i = m_ins; b_d = m_del;
        push_cmd(32'h11, 16'h1, 2'd1);
        push_cmd(32'h22, 16'h2, 2'd1);
        push_cmd(32'h33, 16'h3, 2'd2);
        push_cmd(32'h44, 16'h4, 2'd0);
        push_cmd(32'h55, 16'h5, 2'd3);
        drain();
        chk("t4_insert", 64'(cnt_insert_o), 64'(b_i + 2));
        chk("t4_delete", 64'(cnt_delete_o), 64'(b_d + 1));
        chk("t4_search", 64'(cnt_search_o), 64'(b_s + 1));

        // flush with a coincident push
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(32'hF000_0000 + i, 16'(i), 2'd2);
        b_s = m_srch; b_i = m_ins; b_d = m_del;
        in_key_i = 32'hDEAD; in_value_i = 16'hBEEF; in_opcode_i = 2'd1;
        in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        chk("t5_used", 64'(used_o), 64'd0);
        chk("t5_valid", 64'(out_valid_o), 64'd0);
        chk("t5_cnt", 64'({cnt_search_o, cnt_insert_o, cnt_delete_o}), 64'({16'(b_s), 16'(b_i), 16'(b_d)}));
        push_cmd(32'h7777, 16'h7, 2'd0);
        drain();

        // asynchronous reset mid-burst
        out_ready_i = 1'b0;
        push_cmd(32'hB1, 16'h1, 2'd0);
        push_cmd(32'hB2, 16'h2, 2'd1);
        in_key_i = 32'hB3; in_valid_i = 1'b1;
        @(posedge clk_i); #3;
        rst_i = 1'b0;
        #1;
        chk("t6_valid_now", 64'(out_valid_o), 64'd0);
        chk("t6_ready_now", 64'(in_ready_o), 64'd0);
        chk("t6_used_now", 64'(used_o), 64'd0);
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("t6_ready_back", 64'(in_ready_o), 64'd1);
        chk("t6_empty", 64'(out_valid_o), 64'd0);
        chk("t6_cnt", 64'({cnt_search_o, cnt_insert_o, cnt_delete_o}), 64'd0);
        out_ready_i = 1'b1;
        push_cmd(32'hC0FFEE, 16'h42, 2'd2);
        drain();
        @(posedge clk_i); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
